// File: rtl/regfile_pkg.sv
// Shared types and helpers for the decode-stage register file and its forwarding muxes.
package regfile_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    function automatic int regfile_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_core.sv
// Register array with async clear, one write port, two bypassed read ports
// and a raw debug port that shows only committed array contents.
module regfile_core
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] raw1,
    output logic [DATA_W-1:0] raw2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = regfile_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_en;
    logic              wr_to_zero;

    // A write held during reset must neither commit nor appear on the bypass path.
    always_comb begin
        wr_to_zero = ZERO_REG && (wa == '0);
        wr_en      = we && rst_n && !wr_to_zero;
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        raw1 = mem_q[ra1];
        if (ZERO_REG && (ra1 == '0)) begin
            raw1 = '0;
        end else if (BYPASS && wr_en && (wa == ra1)) begin
            raw1 = wd;
        end
    end

    always_comb begin
        raw2 = mem_q[ra2];
        if (ZERO_REG && (ra2 == '0)) begin
            raw2 = '0;
        end else if (BYPASS && wr_en && (wa == ra2)) begin
            raw2 = wd;
        end
    end

    always_comb begin
        dbg_data = mem_q[dbg_addr];
    end

endmodule

// File: rtl/regfile_fwd.sv
// ID-stage register file wrapper: per-operand forwarding from MEM/WB and the
// branch-equality compare on the forwarded operands.
module regfile_fwd
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [1:0]        fwd_a_sel,
    input  logic [1:0]        fwd_b_sel,
    input  logic [DATA_W-1:0] alu_out_m,
    input  logic [DATA_W-1:0] result_w,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              eq,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] raw1;
    logic [DATA_W-1:0] raw2;
    fwd_sel_t          sel_a;
    fwd_sel_t          sel_b;

    regfile_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (ra1),
        .ra2      (ra2),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .raw1     (raw1),
        .raw2     (raw2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Forwarded values win over register-0 zeroing; the reserved code falls back to the array.
    always_comb begin
        sel_a = fwd_sel_t'(fwd_a_sel);
        sel_b = fwd_sel_t'(fwd_b_sel);
        case (sel_a)
            FWD_MEM: rd1 = alu_out_m;
            FWD_WB:  rd1 = result_w;
            default: rd1 = raw1;
        endcase
        case (sel_b)
            FWD_MEM: rd2 = alu_out_m;
            FWD_WB:  rd2 = result_w;
            default: rd2 = raw2;
        endcase
    end

    always_comb begin
        eq = (rd1 == rd2);
    end

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: directed scenarios plus randomized traffic
// against an array-based reference model; a second instance has bypass disabled.
module tb_regfile_fwd;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, dbg_addr;
    logic        we;
    logic [31:0] wd, alu_out_m, result_w;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] rd1, rd2, dbg_data;
    logic        eq;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;
    logic        eq_nb;

    int vectors;
    int miscompares;

    logic [31:0] model_mem [32];

    regfile_fwd u_dut (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .we(we), .wa(wa), .wd(wd),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .alu_out_m(alu_out_m),
        .result_w(result_w), .rd1(rd1), .rd2(rd2), .eq(eq),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_fwd #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .we(we), .wa(wa), .wd(wd),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .alu_out_m(alu_out_m),
        .result_w(result_w), .rd1(rd1_nb), .rd2(rd2_nb), .eq(eq_nb),
        .dbg_addr(dbg_addr), .dbg_data(dbg_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_raw(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && rst_n && we && (wa == ra)) return wd;
        return model_mem[ra];
    endfunction

    function automatic logic [31:0] exp_op(input logic [1:0] sel, input logic [31:0] raw);
        if (sel == 2'b01) return alu_out_m;
        if (sel == 2'b10) return result_w;
        return raw;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n && we && (wa != 5'd0)) model_mem[wa] = wd;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        tick();
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF;
        ra1 = 5'd3; ra2 = 5'd0; dbg_addr = 5'd3;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        alu_out_m = '0; result_w = '0;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rd1 !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rd1_in_reset got %h exp %h", rd1, 32'd0);
        end
        vectors++;
        if (dbg_data !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_dbg_in_reset got %h exp %h", dbg_data, 32'd0);
        end
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            ra1 = 5'(i); ra2 = 5'(31 - i); dbg_addr = 5'(i);
            #1;
            vectors++;
            if (rd1 !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_rd1[%0d] got %h exp %h", i, rd1, 32'd0);
            end
            vectors++;
            if (rd2 !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_rd2[%0d] got %h exp %h", 31 - i, rd2, 32'd0);
            end
            vectors++;
            if (dbg_data !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_dbg[%0d] got %h exp %h", i, dbg_data, 32'd0);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'h1234_5678);
        @(negedge clk);
        ra1 = 5'd5; dbg_addr = 5'd5; fwd_a_sel = 2'b00;
        #1;
        vectors++;
        if (rd1 !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL write_read_rd1 got %h exp %h", rd1, 32'h1234_5678);
        end
        vectors++;
        if (dbg_data !== 32'h1234_5678) begin
            miscompares++;
            $display("[TB] FAIL write_read_dbg got %h exp %h", dbg_data, 32'h1234_5678);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5_0001;
        ra2 = 5'd7; dbg_addr = 5'd7; fwd_b_sel = 2'b00;
        #1;
        vectors++;
        if (rd2 !== 32'hA5A5_0001) begin
            miscompares++;
            $display("[TB] FAIL bypass_rd2 got %h exp %h", rd2, 32'hA5A5_0001);
        end
        vectors++;
        if (dbg_data !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL bypass_dbg_old got %h exp %h", dbg_data, 32'd0);
        end
        vectors++;
        if (rd2_nb !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL nobypass_rd2 got %h exp %h", rd2_nb, 32'd0);
        end
        tick();
        #1;
        we = 1'b0;
        vectors++;
        if (dbg_data !== 32'hA5A5_0001) begin
            miscompares++;
            $display("[TB] FAIL bypass_dbg_after got %h exp %h", dbg_data, 32'hA5A5_0001);
        end
        vectors++;
        if (rd2_nb !== 32'hA5A5_0001) begin
            miscompares++;
            $display("[TB] FAIL nobypass_rd2_after got %h exp %h", rd2_nb, 32'hA5A5_0001);
        end
    endtask

    task automatic test_reg0();
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra1 = 5'd0; dbg_addr = 5'd0;
        fwd_a_sel = 2'b00;
        #1;
        vectors++;
        if (rd1 !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reg0_same_cycle got %h exp %h", rd1, 32'd0);
        end
        tick();
        #1;
        we = 1'b0;
        vectors++;
        if (rd1 !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reg0_read got %h exp %h", rd1, 32'd0);
        end
        vectors++;
        if (dbg_data !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reg0_dbg got %h exp %h", dbg_data, 32'd0);
        end
        @(negedge clk);
        fwd_a_sel = 2'b01; alu_out_m = 32'h55;
        #1;
        vectors++;
        if (rd1 !== 32'h55) begin
            miscompares++;
            $display("[TB] FAIL reg0_forwarded got %h exp %h", rd1, 32'h55);
        end
    endtask

    task automatic test_fwd_eq();
        do_write(5'd1, 32'd10);
        do_write(5'd2, 32'd20);
        @(negedge clk);
        ra1 = 5'd1; ra2 = 5'd2; alu_out_m = 32'd20; result_w = 32'd0;
        fwd_a_sel = 2'b01; fwd_b_sel = 2'b00;
        #1;
        vectors++;
        if (rd1 !== 32'd20) begin
            miscompares++;
            $display("[TB] FAIL fwd_mem_rd1 got %h exp %h", rd1, 32'd20);
        end
        vectors++;
        if (rd2 !== 32'd20) begin
            miscompares++;
            $display("[TB] FAIL fwd_rf_rd2 got %h exp %h", rd2, 32'd20);
        end
        vectors++;
        if (eq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL eq_equal got %b exp %b", eq, 1'b1);
        end
        @(negedge clk);
        fwd_a_sel = 2'b10; result_w = 32'd21;
        #1;
        vectors++;
        if (rd1 !== 32'd21) begin
            miscompares++;
            $display("[TB] FAIL fwd_wb_rd1 got %h exp %h", rd1, 32'd21);
        end
        vectors++;
        if (eq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL eq_differ got %b exp %b", eq, 1'b0);
        end
        @(negedge clk);
        fwd_a_sel = 2'b11;
        #1;
        vectors++;
        if (rd1 !== 32'd10) begin
            miscompares++;
            $display("[TB] FAIL fwd_rsvd_rd1 got %h exp %h", rd1, 32'd10);
        end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb, ea_nb, eb_nb;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we = 1'($urandom);
            wa = 5'($urandom);
            wd = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            dbg_addr = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
            fwd_a_sel = 2'($urandom);
            fwd_b_sel = 2'($urandom);
            alu_out_m = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            result_w = $urandom;
            #1;
            ea = exp_op(fwd_a_sel, exp_raw(ra1, 1'b1));
            eb = exp_op(fwd_b_sel, exp_raw(ra2, 1'b1));
            ea_nb = exp_op(fwd_a_sel, exp_raw(ra1, 1'b0));
            eb_nb = exp_op(fwd_b_sel, exp_raw(ra2, 1'b0));
            vectors++;
            if (rd1 !== ea) begin
                miscompares++;
                $display("[TB] FAIL rand_rd1 #%0d got %h exp %h", n, rd1, ea);
            end
            vectors++;
            if (rd2 !== eb) begin
                miscompares++;
                $display("[TB] FAIL rand_rd2 #%0d got %h exp %h", n, rd2, eb);
            end
            vectors++;
            if (eq !== (ea == eb)) begin
                miscompares++;
                $display("[TB] FAIL rand_eq #%0d got %b exp %b", n, eq, (ea == eb));
            end
            vectors++;
            if (dbg_data !== model_mem[dbg_addr]) begin
                miscompares++;
                $display("[TB] FAIL rand_dbg #%0d got %h exp %h", n, dbg_data, model_mem[dbg_addr]);
            end
            vectors++;
            if ((rd1_nb !== ea_nb) || (rd2_nb !== eb_nb)) begin
                miscompares++;
                $display("[TB] FAIL rand_nobypass #%0d got %h/%h exp %h/%h", n, rd1_nb, rd2_nb, ea_nb, eb_nb);
            end
            tick();
        end
        #1;
        we = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int r = 1; r <= 4; r++) begin
            do_write(5'(r), 32'h1111_1111 * r + 32'd1);
        end
        @(negedge clk);
        dbg_addr = 5'd4; ra1 = 5'd1; ra2 = 5'd3; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        #1;
        vectors++;
        if (dbg_data !== 32'h4444_4445) begin
            miscompares++;
            $display("[TB] FAIL async_pre_dbg got %h exp %h", dbg_data, 32'h4444_4445);
        end
        #1 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        #1;
        vectors++;
        if (dbg_data !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL async_dbg got %h exp %h", dbg_data, 32'd0);
        end
        vectors++;
        if ((rd1 !== 32'd0) || (rd2 !== 32'd0) || (eq !== 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL async_ops got %h/%h/%b exp 0/0/1", rd1, rd2, eq);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b1;
        we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
        fwd_a_sel = '0; fwd_b_sel = '0; alu_out_m = '0; result_w = '0;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_reg0();
        test_fwd_eq();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- Parametrised register file for the 5-stage pipeline: two combinational read ports, one synchronous write port.
- Same-cycle write-to-read bypass.
- Per-operand decode-stage forwarding mux selecting between the register file, the MEM-stage ALU result and the WB result.
- Branch-equality compare on the forwarded operands.
- Debug read port replaces fixed debug taps.
- Sits in ID; written from WB.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to a read address is returned on the read port.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ra1  in  ADDR_W  read address A (InstrD rs field).
- ra2  in  ADDR_W  read address B (InstrD rt field).
- we  in  1  write enable (RegWriteW).
- wa  in  ADDR_W  write address (WriteRegW).
- wd  in  DATA_W  write data (ResultW).
- fwd_a_sel  in  2  operand A source select.
- fwd_b_sel  in  2  operand B source select.
- alu_out_m  in  DATA_W  MEM-stage ALU result.
- result_w  in  DATA_W  WB-stage result.
- rd1  out  DATA_W  forwarded operand A.
- rd2  out  DATA_W  forwarded operand B.
- eq  out  1  rd1 == rd2.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data, raw array content, no bypass.

Behaviour:
- Reset: rst_n low clears every register to 0 asynchronously. While in reset, rd1/rd2/dbg_data read 0 unless forwarded; eq follows the operands. No write occurs while rst_n is low. Deassertion is synchronised externally; the first write is accepted on the first rising clk with rst_n high.
- Write:
  - On posedge clk, if we=1 (and not (ZERO_REG && wa==0)), mem[wa] <= wd.
  - Exactly one write per cycle.
- Raw read, combinational:
  - raw_i = 0 if ZERO_REG && ra_i==0.
  - Otherwise, if BYPASS && we && wa==ra_i (and wa!=0 when ZERO_REG), raw_i = wd.
  - Otherwise raw_i = mem[ra_i].
- Forwarding per operand, combinational; encodings in package:
  - FWD_RF=2'b00 selects raw.
  - FWD_MEM=2'b01 selects alu_out_m.
  - FWD_WB=2'b10 selects result_w.
  - 2'b11 is reserved and selects raw.
- Forwarding overrides ZERO_REG zeroing. The hazard unit must never forward to register 0; this block does not check.
- eq = (rd1 == rd2), a full DATA_W compare, combinational. Zero read latency.
- Simultaneous write and debug read of the same address: dbg_data shows the old value until the edge.
- wa outside range cannot occur (depth = 2**ADDR_W).

Decomposition:
- regfile_pkg:
  - fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB, FWD_RSVD).
  - Localparam DEPTH derivation helper.
- Sub-module regfile_core (DATA_W, ADDR_W, ZERO_REG, BYPASS):
  - Array, async reset, write port, two bypassed read ports, one raw debug port.
- regfile_fwd instantiates the core and adds the two forwarding muxes and the comparator.

Test Plan:
- Reset then read: rst_n=0 while a write is attempted (we=1, wa=3, wd=0xFFFFFFFF); release, read ra1=3 with sel=00 -> rd1=0, dbg_data(3)=0; all 32 registers read 0.
- Write then read: cycle N we=1, wa=5, wd=0x1234_5678; cycle N+1 ra1=5 -> rd1=0x12345678.
- Bypass, same cycle: we=1, wa=7, wd=0xA5A5_0001 with ra2=7 -> rd2=0xA5A50001 before the edge while dbg_data(7)=old value 0. With BYPASS=0 -> rd2=0.
- Register 0: we=1, wa=0, wd=0xDEAD_BEEF, then ra1=0 -> rd1=0. With fwd_a_sel=01 and alu_out_m=0x55 -> rd1=0x55.
- Forwarding and eq:
  - mem[1]=10, mem[2]=20, alu_out_m=20, fwd_a_sel=01, fwd_b_sel=00, ra1=1, ra2=2 -> rd1=20, rd2=20, eq=1.
  - Switch fwd_a_sel=10 with result_w=21 -> eq=0.
  - fwd_a_sel=11 -> rd1=10.
- Async reset mid-operation: after writes to regs 1..4, assert rst_n low between clock edges -> dbg_data(4) is 0 immediately, without waiting for an edge.
